activation_seq_ctrl: RTL and testbench

ACTIVATION_SEQ_CTRL -- requirements
Module: activation_seq_ctrl

---
 rtl/activation_seq_ctrl_if.sv | 23 ++
 rtl/activation_seq_ctrl.sv | 70 +++++++
 tb/tb_activation_seq_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/activation_seq_ctrl_if.sv
// activation_seq_ctrl_if: upstream beat handshake, sequence control and activation memory outputs
interface activation_seq_ctrl_if;
  logic       start;
  logic       abort;
  logic       act_valid;
  logic [6:0] act_data;
  logic       act_ready;
  logic       weight_done;
  logic [6:0] Activation;
  logic [5:0] Activation_Mem_Address_in;
  logic       load_mem_done;
  logic       Cal;
  logic       busy;
  logic       done;
  modport master (
    output start, abort, act_valid, act_data, weight_done,
    input  act_ready, Activation, Activation_Mem_Address_in, load_mem_done, Cal, busy, done
  );
  modport slave (
    input  start, abort, act_valid, act_data, weight_done,
    output act_ready, Activation, Activation_Mem_Address_in, load_mem_done, Cal, busy, done
  );
endinterface

// File: rtl/activation_seq_ctrl.sv
// activation_seq_ctrl: loads activation words into memory, waits for weights, runs Cal then drains
module activation_seq_ctrl #(
  parameter int NUM_ACT      = 64,
  parameter int CAL_CYCLES   = 8,
  parameter int DRAIN_CYCLES = 15
) (
  input logic clk,
  input logic rst,
  activation_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_W, CAL, DRAIN, DONE} state_t;
  localparam logic [6:0] LAST_BEAT  = 7'(NUM_ACT - 1);
  localparam logic [7:0] CAL_LAST   = 8'(CAL_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  state_t     state, state_n;
  logic [6:0] beat_cnt;
  logic [7:0] cyc_cnt;
  logic       weight_seen;
  logic [6:0] act_q;
  logic [5:0] addr_q;
  logic       accept, cyc_end;
  assign accept  = state == LOAD && bus.act_valid;
  assign cyc_end = cyc_cnt == (state == CAL ? CAL_LAST : DRAIN_LAST);
  always_comb begin
    state_n = state;
    if (state != IDLE && bus.abort) state_n = IDLE;
    else
      case (state)
        IDLE:    state_n = bus.start ? LOAD : IDLE;
        LOAD:    state_n = accept && beat_cnt == LAST_BEAT ? WAIT_W : LOAD;
        WAIT_W:  state_n = weight_seen || bus.weight_done ? CAL : WAIT_W;
        CAL:     state_n = cyc_end ? DRAIN : CAL;
        DRAIN:   state_n = cyc_end ? DONE : DRAIN;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      act_q       <= '0;
      addr_q      <= '0;
      beat_cnt    <= '0;
      cyc_cnt     <= '0;
      weight_seen <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        act_q  <= bus.act_data;
        addr_q <= beat_cnt[5:0];
      end
      if (state == IDLE) begin
        beat_cnt    <= '0;
        weight_seen <= 1'b0;
      end else begin
        if (bus.weight_done) weight_seen <= 1'b1;
        if (accept && !bus.abort) beat_cnt <= beat_cnt + 7'd1;
      end
      // cyc_cnt restarts on every state change so CAL and DRAIN each count from zero
      cyc_cnt <= state_n == state && (state == CAL || state == DRAIN) ? cyc_cnt + 8'd1 : 8'd0;
    end
  end
  assign bus.Activation                = act_q;
  assign bus.Activation_Mem_Address_in = addr_q;
  assign bus.act_ready                 = state == LOAD;
  assign bus.load_mem_done             = state == WAIT_W || state == CAL || state == DRAIN || state == DONE;
  assign bus.Cal                       = state == CAL;
  assign bus.busy                      = state != IDLE;
  assign bus.done                      = state == DONE;
endmodule

// File: tb/tb_activation_seq_ctrl.sv
// tb_activation_seq_ctrl: scenario table with per-cycle output timeline and memory-write scoreboard
module tb_activation_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  activation_seq_ctrl_if bus();
  activation_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    bit gap;
    bit late;
    int beats;
    bit abrt;
    bit xstart;
    int exp_load;
    int exp_wait;
    int exp_writes;
  } row_t;
  row_t        rows [6];
  int          errs = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  logic [12:0] exp_q [$];
  logic [5:0]  last_a = '0;
  logic [6:0]  last_d = '0;
  logic        pend = 1'b0;
  logic        mon_on = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0] ctrl_outs();
    return {bus.act_ready, bus.load_mem_done, bus.Cal, bus.done, bus.busy};
  endfunction
  always @(negedge clk) begin
    if (mon_on) begin
      if (pend) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          {last_a, last_d} = exp_q.pop_front();
        end
      end
      chk("mem_word", 32'({bus.Activation_Mem_Address_in, bus.Activation}), 32'({last_a, last_d}));
      if (rst) begin
        last_a = '0;
        last_d = '0;
      end
      pend = bus.act_valid && bus.act_ready && !bus.abort && !rst;
    end
  end
  task automatic run_row(input row_t r);
    int k = 0;
    int lend = r.exp_load;
    int c0 = r.exp_load + 1 + r.exp_wait;
    int last_n = r.abrt ? c0 + 2 : c0 + 23;
    int w0 = wr_cnt;
    int m;
    bit live;
    logic [4:0] ev;
    for (int n = 0; n <= c0 + 30; n++) begin
      bus.start       = (n == 0) || (r.xstart && (n == 5 || n == c0 + 2));
      bus.abort       = r.abrt && n == c0 + 2;
      bus.weight_done = r.late ? (n == lend + 10) : (n == 10);
      if (n >= 1 && k < r.beats && (!r.gap || n % 2 == 0)) begin
        bus.act_valid = 1'b1;
        bus.act_data  = 7'(k);
        if (n <= lend) exp_q.push_back({6'(k), 7'(k)});
        k++;
      end else bus.act_valid = 1'b0;
      step;
      m    = n + 1;
      live = m <= last_n;
      ev   = {live && m <= lend, live && m > lend, live && m >= c0 && m <= c0 + 7, live && m == c0 + 23, live};
      chk("ctrl_outs", 32'(ctrl_outs()), 32'(ev));
    end
    bus.start = 1'b0; bus.abort = 1'b0; bus.weight_done = 1'b0; bus.act_valid = 1'b0;
    chk("write_count", wr_cnt - w0, r.exp_writes);
    chk("queue_empty", exp_q.size(), 0);
  endtask
  initial begin
    //         gap late beats abrt xstart load wait writes
    rows[0] = '{0, 0, 64, 0, 0,  64,  1, 64};
    rows[1] = '{1, 0, 64, 0, 0, 128,  1, 64};
    rows[2] = '{0, 1, 64, 0, 0,  64, 10, 64};
    rows[3] = '{0, 0, 64, 1, 0,  64,  1, 64};
    rows[4] = '{0, 0, 64, 0, 0,  64,  1, 64};
    rows[5] = '{0, 0, 70, 0, 1,  64,  1, 64};
    bus.start = 1'b0; bus.abort = 1'b0; bus.act_valid = 1'b0; bus.act_data = '0; bus.weight_done = 1'b0;
    step;
    step;
    chk("reset_state", 32'({bus.Activation, bus.Activation_Mem_Address_in, ctrl_outs()}), 32'd0);
    mon_on = 1'b1;
    rst = 1'b0;
    step;
    for (int i = 0; i < 6; i++) run_row(rows[i]);
    bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      bus.act_valid = 1'b1;
      bus.act_data  = 7'(n - 1);
      exp_q.push_back({6'(n - 1), 7'(n - 1)});
      step;
    end
    rst = 1'b1;
    bus.act_data = 7'd30;
    step;
    chk("reset_mid_load", 32'({bus.Activation, bus.Activation_Mem_Address_in, ctrl_outs()}), 32'd0);
    rst = 1'b0;
    bus.act_valid = 1'b0;
    step;
    step;
    chk("queue_after_reset", exp_q.size(), 0);
    run_row(rows[0]);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
